snn_frame_sequencer: RTL and testbench

// - Hardware sequencer for one SNN inference frame on snn_1x1_wrapper.
// - Per frame it:
//   - forwards frame_len input packets into the core packet FIFO;
//   - waits for tick_ready, then issues a single-cycle tick;
//   - waits for the core to settle, then drains the output FIFO into a NUM_OUTPUT-bit spike vector.
// - Replaces host-side per-frame sequencing; sits between the host stream and the wrapper's packet ports.

---
 rtl/snn_frame_sequencer.sv | 172 +++++++++++++++++
 tb/tb_snn_frame_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_frame_sequencer.sv
// snn_frame_sequencer: runs one SNN inference frame on the 1x1 wrapper.
// It feeds the packets, issues a tick, waits for the core to settle, then
// drains the output FIFO into a spike vector.
// Ports:
//   clk, reset (async, active-high)
//   frame_start, frame_len               : frame request from the host
//   in_valid, in_data, in_ready          : host packet stream
//   packet_winc, packet_wdata,
//   packet_wfull                         : core input packet FIFO
//   tick_ready, tick, wait_packets       : core tick control
//   packet_out, packet_out_rempty,
//   packet_out_rinc                      : core output FIFO (FWFT)
//   spike_vec, frame_done, busy,
//   err_timeout, err_range               : results and status
//   spike_count                          : only when SNN_SPIKE_COUNT_EN
// Optional macro: SNN_SPIKE_COUNT_EN adds the spike_count output.
module snn_frame_sequencer #(
   parameter int NUM_OUTPUT  = 250,
   parameter int PKT_W       = 30,
   parameter int OUT_W       = 8,
   parameter int LEN_W       = 7,
   parameter int SETTLE_CYC  = 64,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_start,
   input  logic [LEN_W-1:0]      frame_len,
   input  logic                  in_valid,
   input  logic [PKT_W-1:0]      in_data,
   output logic                  in_ready,
   output logic                  packet_winc,
   output logic [PKT_W-1:0]      packet_wdata,
   input  logic                  packet_wfull,
   input  logic                  tick_ready,
   output logic                  tick,
   input  logic                  wait_packets,
   input  logic [OUT_W-1:0]      packet_out,
   input  logic                  packet_out_rempty,
   output logic                  packet_out_rinc,
   output logic [NUM_OUTPUT-1:0] spike_vec,
   output logic                  frame_done,
   output logic                  busy,
   output logic                  err_timeout,
   output logic                  err_range
`ifdef SNN_SPIKE_COUNT_EN
   ,
   output logic [$clog2(NUM_OUTPUT+1)-1:0] spike_count
`endif
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int IW = $clog2(NUM_OUTPUT);
   localparam int CW = ((OUT_W > IW) ? OUT_W : IW) + 1;
   localparam logic [TW-1:0] SETTLE_T  = TW'(SETTLE_CYC);
   localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT_CYC);

   typedef enum logic [2:0] {
      IDLE, FEED, WAIT_RDY, TICK, SETTLE, DRAIN, GAP, DONE
   } state_t;

   state_t state, state_n;

   logic [LEN_W-1:0] cnt;
   logic [TW-1:0]    timer;
   logic             start;
   logic             to_hit;
   logic [IW-1:0]    idx;
   logic             in_range;

   // Spike index p maps to bit NUM_OUTPUT-1-p (index 0 is the MSB).
   assign idx      = IW'(NUM_OUTPUT - 1) - IW'(packet_out);
   assign in_range = CW'(packet_out) < CW'(NUM_OUTPUT);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n         = state;
      start           = 1'b0;
      to_hit          = 1'b0;
      in_ready        = 1'b0;
      packet_winc     = 1'b0;
      packet_wdata    = '0;
      tick            = 1'b0;
      packet_out_rinc = 1'b0;
      frame_done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (frame_start) begin
               start   = 1'b1;
               state_n = (frame_len == '0) ? WAIT_RDY : FEED;
            end
         end
         FEED: begin
            in_ready     = ~packet_wfull;
            packet_wdata = in_data;
            packet_winc  = in_valid & ~packet_wfull;
            if (packet_winc && cnt == LEN_W'(1)) state_n = WAIT_RDY;
         end
         WAIT_RDY: if (tick_ready) state_n = TICK;
         TICK: begin
            tick    = 1'b1;
            state_n = SETTLE;
         end
         SETTLE: begin
            if (timer >= SETTLE_T && wait_packets) begin
               state_n = DRAIN;
            end else if (timer == TIMEOUT_T) begin
               to_hit  = 1'b1;
               state_n = DRAIN;
            end
         end
         DRAIN: begin
            if (!packet_out_rempty) begin
               packet_out_rinc = 1'b1;
               state_n         = GAP;
            end else begin
               state_n = DONE;
            end
         end
         // Lets the FIFO empty flag catch up with the pop.
         GAP: state_n = DRAIN;
         DONE: begin
            frame_done = 1'b1;
            state_n    = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         timer       <= '0;
         spike_vec   <= '0;
         err_timeout <= 1'b0;
         err_range   <= 1'b0;
      end else begin
         if (start) begin
            cnt         <= frame_len;
            spike_vec   <= '0;
            err_timeout <= 1'b0;
            err_range   <= 1'b0;
         end
         if (packet_winc) cnt <= cnt - LEN_W'(1);
         if (state == TICK) timer <= '0;
         if (state == SETTLE && timer != TIMEOUT_T) timer <= timer + TW'(1);
         if (to_hit) err_timeout <= 1'b1;
         if (packet_out_rinc) begin
            if (in_range) spike_vec[idx] <= 1'b1;
            else          err_range      <= 1'b1;
         end
      end
   end

`ifdef SNN_SPIKE_COUNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         spike_count <= '0;
      end else if (start) begin
         spike_count <= '0;
      end else if (packet_out_rinc && in_range) begin
         spike_count <= spike_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_snn_frame_sequencer.sv
// tb_snn_frame_sequencer: directed scoreboard bench for snn_frame_sequencer.
// Models the core FIFOs; checks packets, ticks and frame results.
module tb_snn_frame_sequencer;

   localparam int N  = 250;
   localparam int PW = 30;
   localparam int OW = 8;
   localparam int LW = 7;
   localparam int SC = 64;
   localparam int TO = 300;
   localparam int CW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          frame_start;
   logic [LW-1:0] frame_len;
   logic          in_valid;
   logic [PW-1:0] in_data;
   logic          in_ready;
   logic          packet_winc;
   logic [PW-1:0] packet_wdata;
   logic          packet_wfull;
   logic          tick_ready;
   logic          tick;
   logic          wait_packets;
   logic [OW-1:0] packet_out;
   logic          packet_out_rempty;
   logic          packet_out_rinc;
   logic [N-1:0]  spike_vec;
   logic          frame_done;
   logic          busy;
   logic          err_timeout;
   logic          err_range;
`ifdef SNN_SPIKE_COUNT_EN
   logic [CW-1:0] spike_count;
`endif

   snn_frame_sequencer #(
      .NUM_OUTPUT(N), .PKT_W(PW), .OUT_W(OW), .LEN_W(LW),
      .SETTLE_CYC(SC), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .frame_start(frame_start), .frame_len(frame_len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .packet_winc(packet_winc), .packet_wdata(packet_wdata),
      .packet_wfull(packet_wfull),
      .tick_ready(tick_ready), .tick(tick),
      .wait_packets(wait_packets),
      .packet_out(packet_out), .packet_out_rempty(packet_out_rempty),
      .packet_out_rinc(packet_out_rinc),
      .spike_vec(spike_vec), .frame_done(frame_done), .busy(busy),
      .err_timeout(err_timeout), .err_range(err_range)
`ifdef SNN_SPIKE_COUNT_EN
      , .spike_count(spike_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] vec;
      logic         terr;
      logic         rerr;
      int           cnt;
      int           npk;
   } frame_t;

   frame_t        exp_f[$];
   logic [PW-1:0] exp_p[$];
   logic [OW-1:0] out_q[$];

   int   n_cmp = 0;
   int   n_bad = 0;
   int   tick_cnt = 0;
   int   winc_cnt = 0;
   int   done_cnt = 0;
   logic pop_pend = 1'b0;

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic miss(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event missing or unexpected", nm);
   endtask

   function automatic void refresh();
      packet_out_rempty = (out_q.size() == 0);
      packet_out        = (out_q.size() == 0) ? '0 : out_q[0];
   endfunction

   // Monitor: packet scoreboard, tick count and frame results.
   always @(negedge clk) begin
      frame_t f;
      if (packet_winc) begin
         winc_cnt++;
         if (exp_p.size() == 0) miss("winc_extra");
         else chk("winc_data", 256'(packet_wdata), 256'(exp_p.pop_front()));
      end
      if (tick) tick_cnt++;
      if (packet_out_rinc) pop_pend = 1'b1;
      if (frame_done) begin
         done_cnt++;
         if (exp_f.size() == 0) begin
            miss("done_extra");
         end else begin
            f = exp_f.pop_front();
            chk("spike_vec", 256'(spike_vec), 256'(f.vec));
            chk("err_timeout", 256'(err_timeout), 256'(f.terr));
            chk("err_range", 256'(err_range), 256'(f.rerr));
            chk("tick_cnt", 256'(tick_cnt), 256'(1));
            chk("winc_cnt", 256'(winc_cnt), 256'(f.npk));
`ifdef SNN_SPIKE_COUNT_EN
            chk("spike_count", 256'(spike_count), 256'(f.cnt));
`endif
            tick_cnt = 0;
            winc_cnt = 0;
         end
      end
   end

   // Output FIFO model: pop lands just after the edge that consumed it.
   always @(posedge clk) begin
      #1;
      if (pop_pend) begin
         if (out_q.size() > 0) void'(out_q.pop_front());
         pop_pend = 1'b0;
      end
      refresh();
   end

   task automatic expect_frame(input logic [N-1:0] v, input logic te,
                               input logic re, input int c, input int np);
      frame_t f;
      f.vec = v; f.terr = te; f.rerr = re; f.cnt = c; f.npk = np;
      exp_f.push_back(f);
   endtask

   task automatic load_out(input logic [OW-1:0] v);
      out_q.push_back(v);
      refresh();
   endtask

   task automatic start_frame(input int len);
      frame_start = 1'b1;
      frame_len   = LW'(len);
      @(posedge clk); #1;
      frame_start = 1'b0;
   endtask

   task automatic send(input logic [PW-1:0] d);
      int k = 0;
      in_valid = 1'b1;
      in_data  = d;
      exp_p.push_back(d);
      @(negedge clk);
      while (!in_ready && k < 100) begin
         k++;
         @(negedge clk);
      end
      if (k >= 100) miss("send_timeout");
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic await_done();
      int k = 0;
      int d0 = done_cnt;
      while (done_cnt == d0 && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 3000) miss("frame_done_timeout");
   endtask

   task automatic await_tick();
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!tick && k < 500);
      if (!tick) miss("tick_timeout");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] v;
      int k;
      reset = 1'b1; frame_start = 1'b0; frame_len = '0;
      in_valid = 1'b0; in_data = '0; packet_wfull = 1'b0;
      tick_ready = 1'b1; wait_packets = 1'b1;
      refresh();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_in_ready", 256'(in_ready), 256'(0));
      chk("rst_winc", 256'(packet_winc), 256'(0));
      chk("rst_wdata", 256'(packet_wdata), 256'(0));
      chk("rst_tick", 256'(tick), 256'(0));
      chk("rst_rinc", 256'(packet_out_rinc), 256'(0));
      chk("rst_done", 256'(frame_done), 256'(0));
      chk("rst_vec", 256'(spike_vec), 256'(0));
      chk("rst_errs", 256'({err_timeout, err_range}), 256'(0));
`ifdef SNN_SPIKE_COUNT_EN
      chk("rst_count", 256'(spike_count), 256'(0));
`endif
      reset = 1'b0;
      @(posedge clk); #1;

      // Nominal frame: outputs 0,5,249 -> bits 249,244,0.
      v = '0; v[249] = 1'b1; v[244] = 1'b1; v[0] = 1'b1;
      expect_frame(v, 1'b0, 1'b0, 3, 3);
      load_out(8'd0); load_out(8'd5); load_out(8'd249);
      start_frame(3);
      chk("busy_feed", 256'(busy), 256'(1));
      send(30'h0AAA_0001); send(30'h1555_0002); send(30'h2F0F_0003);
      await_done();
      repeat (3) @(posedge clk);
      #1;
      chk("vec_hold", 256'(spike_vec), 256'(v));
      chk("idle_busy", 256'(busy), 256'(0));

      // Backpressure: 4-cycle stall after the first packet.
      v = '0; v[248] = 1'b1;
      expect_frame(v, 1'b0, 1'b0, 1, 3);
      load_out(8'd1);
      start_frame(3);
      send(30'h0000_0011);
      packet_wfull = 1'b1;
      in_valid = 1'b1;
      in_data = 30'h0000_0022;
      repeat (4) begin
         @(negedge clk);
         chk("stall_in_ready", 256'(in_ready), 256'(0));
         chk("stall_winc", 256'(packet_winc), 256'(0));
      end
      @(posedge clk); #1;
      packet_wfull = 1'b0;
      send(30'h0000_0022); send(30'h0000_0033);
      await_done();

      // Empty frame: tick held back until tick_ready.
      expect_frame('0, 1'b0, 1'b0, 0, 0);
      tick_ready = 1'b0;
      start_frame(0);
      repeat (5) begin
         @(negedge clk);
         chk("no_tick_early", 256'(tick), 256'(0));
      end
      chk("busy_wait_rdy", 256'(busy), 256'(1));
      @(posedge clk); #1;
      tick_ready = 1'b1;
      await_done();

      // Timeout: wait_packets stays low; drain still happens.
      wait_packets = 1'b0;
      v = '0; v[246] = 1'b1;
      expect_frame(v, 1'b1, 1'b0, 1, 1);
      load_out(8'd3);
      start_frame(1);
      send(30'h0000_0044);
      await_tick();
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!err_timeout && k < TO + 50);
      chk("timeout_not_early", 256'(k >= TO), 256'(1));
      chk("timeout_not_late", 256'(k <= TO + 2), 256'(1));
      @(posedge clk); #1;
      await_done();
      wait_packets = 1'b1;

      // Range and duplicates: 250 out of range, 7 twice -> bit 242.
      v = '0; v[242] = 1'b1;
      expect_frame(v, 1'b0, 1'b1, 2, 2);
      load_out(8'd250); load_out(8'd7); load_out(8'd7);
      start_frame(2);
      chk("terr_cleared", 256'(err_timeout), 256'(0));
      send(30'h0000_0055); send(30'h0000_0066);
      await_done();

      // Reset in SETTLE, then a clean frame.
      start_frame(1);
      send(30'h0000_0077);
      await_tick();
      repeat (10) @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", 256'(busy), 256'(0));
      chk("mid_rst_tick", 256'(tick), 256'(0));
      chk("mid_rst_rinc", 256'(packet_out_rinc), 256'(0));
      chk("mid_rst_done", 256'(frame_done), 256'(0));
      chk("mid_rst_vec", 256'(spike_vec), 256'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      tick_cnt = 0;
      winc_cnt = 0;
      v = '0; v[239] = 1'b1; v[229] = 1'b1;
      expect_frame(v, 1'b0, 1'b0, 2, 2);
      load_out(8'd10); load_out(8'd20);
      start_frame(2);
      send(30'h0000_0088); send(30'h0000_0099);
      await_done();

      repeat (3) @(posedge clk);
      #1;
      if (exp_f.size() != 0) miss("frames_left");
      if (exp_p.size() != 0) miss("packets_left");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
